ex_stage: RTL and testbench

- Execute stage of the RV32I 5-stage pipeline; consumes the ID/EX register outputs directly.
- Selects operands, computes the ALU result, resolves conditional branches and registers everything into the EX/MEM boundary.
- Holds on stall, bubbles on flush, and self-squashes the wrong-path instruction that follows a taken branch.

---
 rtl/ex_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage feeding the EX/MEM boundary.
// Optional feature macro: EX_FWD_EN adds MEM/WB operand forwarding ports.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   pc_in, rs1/rs2_val_in      instruction PC and register operands
//   imm_in, rd_in              immediate and destination register
//   funct3_in, funct7_in       ALU/branch function select (funct7_in = bit 30)
//   alu_src_in, branch_in      operand-B select, conditional branch marker
//   alu_op_in, reg_write_in    ALU op class, register write enable
//   stall, flush               hold / bubble controls
//   *_out                      registered EX/MEM results
//   (EX_FWD_EN) mem_fwd_*, wb_fwd_*, rs1_in, rs2_in forwarding sources
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_val_in,
    input  logic [XLEN-1:0] rs2_val_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            funct7_in,
    input  logic            alu_src_in,
    input  logic            branch_in,
    input  logic [1:0]      alu_op_in,
    input  logic            reg_write_in,
    input  logic            stall,
    input  logic            flush,
`ifdef EX_FWD_EN
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_val,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
`endif
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            branch_taken_out,
    output logic [XLEN-1:0] branch_target_out,
    output logic            valid_out
);

    localparam int unsigned SHW = 5;

    logic [XLEN-1:0] rs1_v, rs2_v, op_b, alu_c, target_c;
    logic [SHW-1:0]  shamt;
    logic            taken_c, eq_c, lt_c, ltu_c;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            taken_q, taken_d;
    logic            valid_q, valid_d;
    logic            squash_q, squash_d;

    // Operand selection, with MEM taking priority over WB when forwarding exists.
`ifdef EX_FWD_EN
    always_comb begin
        rs1_v = rs1_val_in;
        rs2_v = rs2_val_in;
        if (mem_fwd_en && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs1_in)
            rs1_v = mem_fwd_val;
        else if (wb_fwd_en && wb_fwd_rd != 5'd0 && wb_fwd_rd == rs1_in)
            rs1_v = wb_fwd_val;
        if (mem_fwd_en && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs2_in)
            rs2_v = mem_fwd_val;
        else if (wb_fwd_en && wb_fwd_rd != 5'd0 && wb_fwd_rd == rs2_in)
            rs2_v = wb_fwd_val;
    end
`else
    assign rs1_v = rs1_val_in;
    assign rs2_v = rs2_val_in;
`endif

    assign op_b     = alu_src_in ? imm_in : rs2_val_sel();
    assign shamt    = op_b[SHW-1:0];
    assign target_c = pc_in + imm_in;

    function automatic logic [XLEN-1:0] rs2_val_sel();
        return rs2_v;
    endfunction

    // ALU; the branch-compare class produces rs1 - B as its result.
    always_comb begin
        alu_c = rs1_v + op_b;
        case (alu_op_in)
            2'b01: alu_c = rs1_v - op_b;
            2'b10: begin
                case (funct3_in)
                    3'b000: alu_c = (funct7_in && !alu_src_in) ? rs1_v - op_b : rs1_v + op_b;
                    3'b001: alu_c = rs1_v << shamt;
                    3'b010: alu_c = XLEN'($signed(rs1_v) < $signed(op_b));
                    3'b011: alu_c = XLEN'(rs1_v < op_b);
                    3'b100: alu_c = rs1_v ^ op_b;
                    3'b101: alu_c = funct7_in ? XLEN'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
                    3'b110: alu_c = rs1_v | op_b;
                    default: alu_c = rs1_v & op_b;
                endcase
            end
            default: alu_c = rs1_v + op_b;
        endcase
    end

    // Branch resolution always compares against rs2, never the immediate.
    assign eq_c  = (rs1_v == rs2_v);
    assign lt_c  = ($signed(rs1_v) < $signed(rs2_v));
    assign ltu_c = (rs1_v < rs2_v);

    always_comb begin
        taken_c = 1'b0;
        case (funct3_in)
            3'b000: taken_c = eq_c;
            3'b001: taken_c = !eq_c;
            3'b100: taken_c = lt_c;
            3'b101: taken_c = !lt_c;
            3'b110: taken_c = ltu_c;
            3'b111: taken_c = !ltu_c;
            default: taken_c = 1'b0;
        endcase
        taken_c = taken_c && branch_in;
    end

    // EX/MEM update priority: flush > stall > squash > load.
    always_comb begin
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        target_d     = target_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        taken_d      = taken_q;
        valid_d      = valid_q;
        squash_d     = squash_q;
        if (flush) begin
            reg_write_d = 1'b0;
            taken_d     = 1'b0;
            valid_d     = 1'b0;
            squash_d    = 1'b0;
        end else if (!stall) begin
            alu_result_d = alu_c;
            store_data_d = rs2_v;
            target_d     = target_c;
            rd_d         = rd_in;
            if (squash_q) begin
                // Wrong-path instruction behind a taken branch: load as a bubble.
                reg_write_d = 1'b0;
                taken_d     = 1'b0;
                valid_d     = 1'b0;
                squash_d    = 1'b0;
            end else begin
                reg_write_d = reg_write_in && (rd_in != 5'd0);
                taken_d     = taken_c;
                valid_d     = 1'b1;
                squash_d    = taken_c;
            end
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            target_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            taken_q      <= 1'b0;
            valid_q      <= 1'b0;
            squash_q     <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            target_q     <= target_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            taken_q      <= taken_d;
            valid_q      <= valid_d;
            squash_q     <= squash_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign rd_out            = rd_q;
    assign reg_write_out     = reg_write_q;
    assign branch_taken_out  = taken_q;
    assign branch_target_out = target_q;
    assign valid_out         = valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage (default and EX_FWD_EN builds).
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, rs1_val_in, rs2_val_in, imm_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        funct7_in, alu_src_in, branch_in, reg_write_in, stall, flush;
    logic [1:0]  alu_op_in;
    logic [31:0] alu_result_out, store_data_out, branch_target_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, branch_taken_out, valid_out;
`ifdef EX_FWD_EN
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd, rs1_in, rs2_in;
    logic [31:0] mem_fwd_val, wb_fwd_val;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .rs1_val_in(rs1_val_in),
        .rs2_val_in(rs2_val_in), .imm_in(imm_in), .rd_in(rd_in),
        .funct3_in(funct3_in), .funct7_in(funct7_in), .alu_src_in(alu_src_in),
        .branch_in(branch_in), .alu_op_in(alu_op_in), .reg_write_in(reg_write_in),
        .stall(stall), .flush(flush),
`ifdef EX_FWD_EN
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_val(wb_fwd_val),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
`endif
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .rd_out(rd_out), .reg_write_out(reg_write_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7, src, br;
        logic [1:0]  op;
        logic        rw;
        logic        chk_alu;
        logic [31:0] exp_alu;
        logic        exp_taken;
        logic [31:0] exp_tgt;
        logic        exp_rw;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                                input logic [2:0] f3, input logic f7, src, br,
                                input logic [1:0] op, input logic rw, chk_alu,
                                input logic [31:0] exp_alu, input logic exp_taken,
                                input logic [31:0] exp_tgt, input logic exp_rw);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd; v.f3 = f3;
        v.f7 = f7; v.src = src; v.br = br; v.op = op; v.rw = rw; v.chk_alu = chk_alu;
        v.exp_alu = exp_alu; v.exp_taken = exp_taken; v.exp_tgt = exp_tgt; v.exp_rw = exp_rw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_in = v.pc; rs1_val_in = v.rs1; rs2_val_in = v.rs2; imm_in = v.imm;
        rd_in = v.rd; funct3_in = v.f3; funct7_in = v.f7; alu_src_in = v.src;
        branch_in = v.br; alu_op_in = v.op; reg_write_in = v.rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string name, input logic v, rw, tk);
        check({name, ".valid"}, 32'(valid_out), 32'(v));
        check({name, ".reg_write"}, 32'(reg_write_out), 32'(rw));
        check({name, ".taken"}, 32'(branch_taken_out), 32'(tk));
    endtask

    vec_t vecs[16];
    vec_t add_v, blt_v, bgeu_v, v_tmp;

    initial begin
        // pc, rs1, rs2, imm, rd, f3, f7, src, br, op, rw, chk, alu, taken, tgt, rw_out
        vecs[0]  = mk(32'h0, 32'd5, 32'd7, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'd12, 1'b0, 32'h0, 1'b1);
        vecs[1]  = mk(32'h4, 32'd0, 32'd1, 32'h0, 5'd4, 3'b000, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h4, 1'b1);
        vecs[2]  = mk(32'h8, 32'h80000000, 32'd0, 32'd4, 5'd5, 3'b101, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'hF8000000, 1'b0, 32'hC, 1'b1);
        vecs[3]  = mk(32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 5'd6, 3'b011, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'd1, 1'b0, 32'h0, 1'b1);
        vecs[4]  = mk(32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd7, 3'b010, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'd1, 1'b0, 32'h0, 1'b1);
        vecs[5]  = mk(32'h0, 32'h80000000, 32'd4, 32'h0, 5'd8, 3'b101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h08000000, 1'b0, 32'h0, 1'b1);
        vecs[6]  = mk(32'h0, 32'd1, 32'h21, 32'h0, 5'd9, 3'b001, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'd2, 1'b0, 32'h0, 1'b1);
        vecs[7]  = mk(32'h0, 32'hF0F0, 32'hFF00, 32'h0, 5'd10, 3'b100, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h0FF0, 1'b0, 32'h0, 1'b1);
        vecs[8]  = mk(32'h0, 32'hF0F0, 32'hFF00, 32'h0, 5'd11, 3'b110, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'hFFF0, 1'b0, 32'h0, 1'b1);
        vecs[9]  = mk(32'h0, 32'hF0F0, 32'hFF00, 32'h0, 5'd12, 3'b111, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'hF000, 1'b0, 32'h0, 1'b1);
        vecs[10] = mk(32'h0, 32'd5, 32'd7, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0);
        vecs[11] = mk(32'h0, 32'd10, 32'd99, 32'd3, 5'd1, 3'b000, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'd13, 1'b0, 32'd3, 1'b1);
        vecs[12] = mk(32'h0, 32'd2, 32'd3, 32'h0, 5'd2, 3'b100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'd5, 1'b0, 32'h0, 1'b1);
        vecs[13] = mk(32'hFFFFFFF0, 32'd2, 32'd3, 32'h20, 5'd2, 3'b111, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'd5, 1'b0, 32'h10, 1'b0);
        vecs[14] = mk(32'h200, 32'd5, 32'd6, 32'd5, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 32'h205, 1'b0);
        vecs[15] = mk(32'h300, 32'd4, 32'd4, 32'h10, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 32'h310, 1'b0);

        add_v  = vecs[0];
        blt_v  = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 3'b100, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0);
        bgeu_v = mk(32'h40, 32'hFFFFFFFF, 32'd1, 32'h8, 5'd0, 3'b111, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 32'h48, 1'b0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(vecs[0]);
`ifdef EX_FWD_EN
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        mem_fwd_val = 32'h0; wb_fwd_val = 32'h0; rs1_in = 5'd0; rs2_in = 5'd0;
`endif
        tick();
        tick();
        check("reset.alu", alu_result_out, 32'h0);
        check("reset.tgt", branch_target_out, 32'h0);
        check("reset.store", store_data_out, 32'h0);
        check("reset.rd", 32'(rd_out), 32'h0);
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Table of single-cycle vectors, none of which takes a branch.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            tick();
            if (vecs[i].chk_alu) check($sformatf("vec%0d.alu", i), alu_result_out, vecs[i].exp_alu);
            check($sformatf("vec%0d.tgt", i), branch_target_out, vecs[i].exp_tgt);
            check($sformatf("vec%0d.rd", i), 32'(rd_out), 32'(vecs[i].rd));
            check($sformatf("vec%0d.store", i), store_data_out, vecs[i].rs2);
            check_ctl($sformatf("vec%0d", i), 1'b1, vecs[i].exp_rw, vecs[i].exp_taken);
        end

        // Taken branch squashes exactly the next instruction.
        drive(blt_v); tick();
        check("blt.tgt", branch_target_out, 32'h120);
        check_ctl("blt", 1'b1, 1'b0, 1'b1);
        drive(add_v); tick();
        check_ctl("squashed", 1'b0, 1'b0, 1'b0);
        tick();
        check("after_squash.alu", alu_result_out, 32'd12);
        check_ctl("after_squash", 1'b1, 1'b1, 1'b0);

        // Stall after a taken branch holds it; squash applies at the next live edge.
        drive(bgeu_v); tick();
        check("bgeu.tgt", branch_target_out, 32'h48);
        check_ctl("bgeu", 1'b1, 1'b0, 1'b1);
        stall = 1'b1; drive(add_v); tick();
        check("bgeu_stall.tgt", branch_target_out, 32'h48);
        check_ctl("bgeu_stall", 1'b1, 1'b0, 1'b1);
        stall = 1'b0; tick();
        check_ctl("bgeu_squash", 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("bgeu_after", 1'b1, 1'b1, 1'b0);

        // Flush after a taken branch clears the squash flag.
        drive(blt_v); tick();
        flush = 1'b1; drive(add_v); tick();
        check_ctl("flush", 1'b0, 1'b0, 1'b0);
        check("flush.tgt_hold", branch_target_out, 32'h120);
        flush = 1'b0; tick();
        check("flush_after.alu", alu_result_out, 32'd12);
        check_ctl("flush_after", 1'b1, 1'b1, 1'b0);

        // Two-cycle stall with changing inputs, then flush+stall together.
        v_tmp = add_v; v_tmp.rs1 = 32'd1; v_tmp.rs2 = 32'd1; v_tmp.rd = 5'd4;
        drive(v_tmp); tick();
        check("pre_stall.alu", alu_result_out, 32'd2);
        stall = 1'b1; v_tmp.rs1 = 32'd9; v_tmp.rs2 = 32'd9; v_tmp.rd = 5'd20;
        drive(v_tmp);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stall%0d.alu", k), alu_result_out, 32'd2);
            check($sformatf("stall%0d.rd", k), 32'(rd_out), 32'd4);
            check_ctl($sformatf("stall%0d", k), 1'b1, 1'b1, 1'b0);
        end
        stall = 1'b0; tick();
        check("unstall.alu", alu_result_out, 32'd18);
        check("unstall.rd", 32'(rd_out), 32'd20);
        stall = 1'b1; flush = 1'b1; tick();
        check_ctl("flush_stall", 1'b0, 1'b0, 1'b0);
        check("flush_stall.alu_hold", alu_result_out, 32'd18);
        stall = 1'b0; flush = 1'b0; tick();
        check_ctl("flush_stall_after", 1'b1, 1'b1, 1'b0);

        // Reset between edges clears outputs at once and drops a pending squash.
        drive(blt_v); tick();
        check_ctl("pre_reset", 1'b1, 1'b0, 1'b1);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_reset.alu", alu_result_out, 32'h0);
        check("async_reset.tgt", branch_target_out, 32'h0);
        check_ctl("async_reset", 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0; stall = 1'b0;
        drive(add_v); tick();
        check("post_reset.alu", alu_result_out, 32'd12);
        check_ctl("post_reset", 1'b1, 1'b1, 1'b0);

`ifdef EX_FWD_EN
        // MEM forwarding wins over WB; rd=0 on MEM falls back to WB.
        v_tmp = add_v; v_tmp.rs1 = 32'd7; v_tmp.rs2 = 32'd1;
        drive(v_tmp);
        rs1_in = 5'd2; rs2_in = 5'd5;
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_val = 32'd100;
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd2; wb_fwd_val = 32'd200;
        tick();
        check("fwd_mem.alu", alu_result_out, 32'd101);
        mem_fwd_rd = 5'd0; tick();
        check("fwd_wb.alu", alu_result_out, 32'd201);
        rs2_in = 5'd2; tick();
        check("fwd_rs2.store", store_data_out, 32'd200);
        check("fwd_rs2.alu", alu_result_out, 32'd400);
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
